mux8_rr_scheduler: RTL and testbench



---
 rtl/mux8_rr_scheduler_if.sv | 30 +++
 rtl/mux8_rr_scheduler.sv | 103 ++++++++++
 tb/tb_mux8_rr_scheduler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mux8_rr_scheduler_if.sv
// rtl/mux8_rr_scheduler_if.sv - request/data/grant bundle for the 8:1 round-robin mux scheduler
interface mux8_rr_scheduler_if;
    logic [7:0] req;
    logic [7:0] in;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       valid;
    logic       y;
    logic       last;

    modport master (
        output req,
        output in,
        input  sel,
        input  grant,
        input  valid,
        input  y,
        input  last
    );

    modport slave (
        input  req,
        input  in,
        output sel,
        output grant,
        output valid,
        output y,
        output last
    );
endinterface

// File: rtl/mux8_rr_scheduler.sv
// rtl/mux8_rr_scheduler.sv - round-robin grant of one shared 8:1 mux line with a hold budget
module mux8_rr_scheduler #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mux8_rr_scheduler_if.slave   bus
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic       LAST_ON_LOAD = (HOLD_CYCLES == 1);

    logic [0:0] state;
    logic [2:0] ptr;
    logic [7:0] cnt;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       valid;
    logic       last;

    logic       end_grant;
    logic [2:0] scan_base;
    logic [3:0] arb;
    logic [7:0] cnt_inc;

    // {found, index}: first requester scanning base, base+1, ... modulo 8
    function automatic logic [3:0] arbitrate(input logic [7:0] r, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = base + 3'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        end_grant = (state == ST_GRANT) && (!bus.req[sel] || (cnt == CNT_LAST));
        scan_base = end_grant ? (sel + 3'd1) : ptr;
        arb       = arbitrate(bus.req, scan_base);
        cnt_inc   = cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= 3'd0;
            cnt   <= 8'd0;
            sel   <= 3'd0;
            grant <= 8'd0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb[3]) begin
                        state <= ST_GRANT;
                        sel   <= arb[2:0];
                        grant <= 8'd1 << arb[2:0];
                        valid <= 1'b1;
                        cnt   <= 8'd0;
                        last  <= LAST_ON_LOAD;
                    end
                end
                ST_GRANT: begin
                    if (end_grant) begin
                        ptr <= scan_base;
                        cnt <= 8'd0;
                        if (arb[3]) begin
                            sel   <= arb[2:0];
                            grant <= 8'd1 << arb[2:0];
                            valid <= 1'b1;
                            last  <= LAST_ON_LOAD;
                        end else begin
                            // sel deliberately keeps the last winner while idle
                            state <= ST_IDLE;
                            grant <= 8'd0;
                            valid <= 1'b0;
                            last  <= 1'b0;
                        end
                    end else begin
                        cnt  <= cnt_inc;
                        last <= (cnt_inc == CNT_LAST);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= 8'd0;
                    valid <= 1'b0;
                    last  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel   = sel;
    assign bus.grant = grant;
    assign bus.valid = valid;
    assign bus.last  = last;
    assign bus.y     = valid ? bus.in[sel] : 1'b0;
endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// tb/tb_mux8_rr_scheduler.sv - directed self-checking bench for mux8_rr_scheduler (HOLD_CYCLES=4)
module tb_mux8_rr_scheduler;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux8_rr_scheduler_if bus();

    mux8_rr_scheduler #(.HOLD_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = 8'h00;
        bus.in  = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.req = 8'hFF;
        bus.in  = 8'hFF;
        tick();
        tick();
        checks++;
        if (bus.sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", bus.sel); end
        checks++;
        if (bus.grant !== 8'h00) begin errors++; $display("FAIL reset_grant: got %h want 00", bus.grant); end
        checks++;
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        checks++;
        if (bus.last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", bus.last); end
        checks++;
        if (bus.y !== 1'b0) begin errors++; $display("FAIL reset_y: got %b want 0", bus.y); end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.grant !== 8'h01 || bus.sel !== 3'd0 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: got grant=%h sel=%0d valid=%b want 01/0/1", bus.grant, bus.sel, bus.valid);
        end
    endtask

    task automatic test_single_requester();
        logic exp_last;
        do_reset();
        bus.in = 8'h08;
        checks++;
        if (bus.y !== 1'b0 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pre_grant: got y=%b valid=%b want 0/0", bus.y, bus.valid);
        end
        bus.req = 8'b0000_1000;
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_last = (c % 4 == 0);
            checks++;
            if (bus.grant !== 8'h08 || bus.sel !== 3'd3 || bus.valid !== 1'b1) begin
                errors++;
                $display("FAIL single_grant c%0d: got grant=%h sel=%0d valid=%b want 08/3/1", c, bus.grant, bus.sel, bus.valid);
            end
            checks++;
            if (bus.last !== exp_last) begin
                errors++;
                $display("FAIL single_last c%0d: got %b want %b", c, bus.last, exp_last);
            end
            bus.in = (c % 2 == 1) ? 8'hF7 : 8'h08;
            #1;
            checks++;
            if (bus.y !== bus.in[3]) begin
                errors++;
                $display("FAIL single_y c%0d: got %b want %b", c, bus.y, bus.in[3]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_sel;
        logic [7:0] exp_grant;
        logic       exp_last;
        do_reset();
        bus.req = 8'hFF;
        for (int c = 1; c <= 36; c++) begin
            tick();
            exp_sel   = 3'(((c - 1) / 4) % 8);
            exp_grant = 8'd1 << exp_sel;
            exp_last  = (c % 4 == 0);
            checks++;
            if (bus.sel !== exp_sel || bus.grant !== exp_grant || bus.valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_grant c%0d: got sel=%0d grant=%h valid=%b want %0d/%h/1", c, bus.sel, bus.grant, bus.valid, exp_sel, exp_grant);
            end
            checks++;
            if (bus.last !== exp_last) begin
                errors++;
                $display("FAIL b2b_last c%0d: got %b want %b", c, bus.last, exp_last);
            end
        end
    endtask

    task automatic test_wrap();
        logic [2:0] exp_sel;
        do_reset();
        bus.req = 8'b1000_0000;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 1) bus.req = 8'b1000_0001;
            exp_sel = ((((c - 1) / 4) % 2) == 0) ? 3'd7 : 3'd0;
            checks++;
            if (bus.sel !== exp_sel || bus.grant !== (8'd1 << exp_sel) || bus.valid !== 1'b1) begin
                errors++;
                $display("FAIL wrap c%0d: got sel=%0d grant=%h valid=%b want sel=%0d", c, bus.sel, bus.grant, bus.valid, exp_sel);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        bus.req = 8'b0010_0100;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if (bus.sel !== 3'd2 || bus.grant !== 8'h04 || bus.last !== 1'b0) begin
                errors++;
                $display("FAIL early_hold c%0d: got sel=%0d grant=%h last=%b want 2/04/0", c, bus.sel, bus.grant, bus.last);
            end
        end
        bus.req = 8'b0010_0000;
        tick();
        checks++;
        if (bus.sel !== 3'd5 || bus.grant !== 8'h20 || bus.valid !== 1'b1 || bus.last !== 1'b0) begin
            errors++;
            $display("FAIL early_switch: got sel=%0d grant=%h valid=%b last=%b want 5/20/1/0", bus.sel, bus.grant, bus.valid, bus.last);
        end
        tick();
        tick();
        tick();
        checks++;
        if (bus.sel !== 3'd5 || bus.last !== 1'b1) begin
            errors++;
            $display("FAIL early_new_expiry: got sel=%0d last=%b want 5/1", bus.sel, bus.last);
        end
        bus.req = 8'h00;
        tick();
        checks++;
        if (bus.valid !== 1'b0 || bus.grant !== 8'h00 || bus.sel !== 3'd5 || bus.y !== 1'b0) begin
            errors++;
            $display("FAIL early_idle: got valid=%b grant=%h sel=%0d y=%b want 0/00/5/0", bus.valid, bus.grant, bus.sel, bus.y);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        bus.in  = 8'hFF;
        bus.req = 8'b0010_0000;
        tick();
        bus.req = 8'h21;
        tick();
        checks++;
        if (bus.sel !== 3'd5 || bus.grant !== 8'h20) begin
            errors++;
            $display("FAIL midrst_setup: got sel=%0d grant=%h want 5/20", bus.sel, bus.grant);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.sel !== 3'd0 || bus.grant !== 8'h00 || bus.valid !== 1'b0 || bus.last !== 1'b0 || bus.y !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: got sel=%0d grant=%h valid=%b last=%b y=%b want all 0", bus.sel, bus.grant, bus.valid, bus.last, bus.y);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.sel !== 3'd0 || bus.grant !== 8'h01 || bus.valid !== 1'b1 || bus.y !== 1'b1) begin
            errors++;
            $display("FAIL midrst_regrant: got sel=%0d grant=%h valid=%b y=%b want 0/01/1/1", bus.sel, bus.grant, bus.valid, bus.y);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.req = 8'h00;
        bus.in  = 8'h00;
        test_reset();
        test_single_requester();
        test_back_to_back();
        test_wrap();
        test_early_release();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
